hex_word_parser: RTL and testbench

- Streaming ASCII-hex-to-binary word parser for the host command/UART receive path.
- Accepts one ASCII character per handshake and accumulates up to NUM_DIGITS hex digits, MSB first, into one word.
- Emits the word on a delimiter or when the digit limit is reached, with digit count and error status.
- Successor to the single-character hex converter: adds parametrised width, a valid/ready stream interface, a word-level FSM and error recovery.

---
 rtl/hex_parse_pkg.sv | 27 ++
 rtl/hex_char_class.sv | 25 ++
 rtl/hex_word_parser.sv | 139 +++++++++++++
 tb/tb_hex_word_parser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_parse_pkg.sv
// hex_parse_pkg: shared ASCII constants, error codes and FSM encoding for the hex word parser.
package hex_parse_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_BADCHAR  = 2'd1,
        ERR_OVERFLOW = 2'd2
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SKIP = 2'd2
    } state_e;

endpackage

// File: rtl/hex_char_class.sv
// hex_char_class: classifies one ASCII character as hex digit (with its nibble) or word delimiter.
module hex_char_class
    import hex_parse_pkg::*;
#(
    parameter int ALLOW_LOWER = 1
) (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_digit,
    output logic       is_delim
);

    logic is_num;
    logic is_up;
    logic is_lo;

    assign is_num   = (ch >= CH_0) && (ch <= CH_9);
    assign is_up    = (ch >= CH_UA) && (ch <= CH_UF);
    assign is_lo    = (ALLOW_LOWER != 0) && (ch >= CH_LA) && (ch <= CH_LF);
    assign is_digit = is_num | is_up | is_lo;
    assign is_delim = (ch == CH_SP) | (ch == CH_CR) | (ch == CH_NL) | (ch == CH_COMMA);
    // 'A'..'F' and 'a'..'f' both have low nibble 1..6, so +9 maps them to 10..15
    assign nibble   = is_num ? ch[3:0] : ch[3:0] + 4'd9;

endmodule

// File: rtl/hex_word_parser.sv
// hex_word_parser: streams ASCII hex characters into words, emitting value, digit count and error status.
module hex_word_parser
    import hex_parse_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int AUTO_EMIT   = 1,
    parameter int ALLOW_LOWER = 1
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic                               iCLR,
    input  logic [7:0]                         iCHAR,
    input  logic                               iVALID,
    output logic                               oREADY,
    output logic                               oVALID,
    input  logic                               iREADY,
    output logic [4*NUM_DIGITS-1:0]            oD,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    oDIGITS,
    output logic [1:0]                         oERR
);

    localparam int DATA_WIDTH = 4 * NUM_DIGITS;
    localparam int CW         = $clog2(NUM_DIGITS + 1);

    state_e                state, state_n;
    err_e                  code, code_n, emit_err;
    logic [DATA_WIDTH-1:0] acc, acc_n, acc_sh, emit_d;
    logic [CW-1:0]         cnt, cnt_n, cnt_inc, emit_cnt;
    logic [3:0]            nibble;
    logic                  is_digit, is_delim, take, emit;

    hex_char_class #(.ALLOW_LOWER(ALLOW_LOWER)) u_class (
        .ch       (iCHAR),
        .nibble   (nibble),
        .is_digit (is_digit),
        .is_delim (is_delim)
    );

    assign oREADY  = ~oVALID | iREADY;
    assign take    = iVALID & oREADY;
    assign acc_sh  = {acc[DATA_WIDTH-5:0], nibble};
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        code_n   = code;
        emit     = 1'b0;
        emit_d   = '0;
        emit_cnt = '0;
        emit_err = ERR_OK;
        if (take) begin
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        acc_n   = DATA_WIDTH'(nibble);
                        cnt_n   = CW'(1);
                        state_n = ACC;
                    end else if (!is_delim) begin
                        code_n  = ERR_BADCHAR;
                        state_n = SKIP;
                    end
                end
                ACC: begin
                    if (is_digit && cnt == CW'(NUM_DIGITS)) begin
                        code_n  = ERR_OVERFLOW;
                        state_n = SKIP;
                    end else if (is_digit && AUTO_EMIT != 0 && cnt_inc == CW'(NUM_DIGITS)) begin
                        emit     = 1'b1;
                        emit_d   = acc_sh;
                        emit_cnt = cnt_inc;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end else if (is_digit) begin
                        acc_n = acc_sh;
                        cnt_n = cnt_inc;
                    end else if (is_delim) begin
                        emit     = 1'b1;
                        emit_d   = acc;
                        emit_cnt = cnt;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end else begin
                        code_n  = ERR_BADCHAR;
                        state_n = SKIP;
                    end
                end
                SKIP: begin
                    if (is_delim) begin
                        emit     = 1'b1;
                        emit_err = code;
                        code_n   = ERR_OK;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            code    <= ERR_OK;
            oVALID  <= 1'b0;
            oD      <= '0;
            oDIGITS <= '0;
            oERR    <= ERR_OK;
        end else if (iCLR) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            code   <= ERR_OK;
            oVALID <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            code  <= code_n;
            // result registers only change on emission so they hold under backpressure
            if (emit) begin
                oVALID  <= 1'b1;
                oD      <= emit_d;
                oDIGITS <= emit_cnt;
                oERR    <= emit_err;
            end else if (iREADY) begin
                oVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_word_parser.sv
// tb_hex_word_parser: scoreboard bench for two parser configurations (auto-emit/lowercase and strict).
module tb_hex_word_parser;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  n;
        logic [1:0]  e;
    } exp_t;

    logic        CLK;
    logic        RST_N;
    logic        a_clr, a_valid, a_ready, a_ovalid, a_iready;
    logic [7:0]  a_char;
    logic [31:0] a_d;
    logic [3:0]  a_dig;
    logic [1:0]  a_err;
    logic        b_clr, b_valid, b_ready, b_ovalid, b_iready;
    logic [7:0]  b_char;
    logic [31:0] b_d;
    logic [3:0]  b_dig;
    logic [1:0]  b_err;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    hex_word_parser #(.NUM_DIGITS(8), .AUTO_EMIT(1), .ALLOW_LOWER(1)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .iCLR(a_clr), .iCHAR(a_char), .iVALID(a_valid),
        .oREADY(a_ready), .oVALID(a_ovalid), .iREADY(a_iready),
        .oD(a_d), .oDIGITS(a_dig), .oERR(a_err)
    );

    hex_word_parser #(.NUM_DIGITS(8), .AUTO_EMIT(0), .ALLOW_LOWER(0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .iCLR(b_clr), .iCHAR(b_char), .iVALID(b_valid),
        .oREADY(b_ready), .oVALID(b_ovalid), .iREADY(b_iready),
        .oD(b_d), .oDIGITS(b_dig), .oERR(b_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 just after the character was accepted
    task automatic send(input bit sel, input logic [7:0] c);
        int n = 0;
        if (sel) begin b_char = c; b_valid = 1'b1; end
        else begin a_char = c; a_valid = 1'b1; end
        @(negedge CLK);
        while (!(sel ? b_ready : a_ready) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!(sel ? b_ready : a_ready)) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for char %0h", c);
        end
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic send_str(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) send(sel, s[i]);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] n, input logic [1:0] e);
        mk.d = d;
        mk.n = n;
        mk.e = e;
    endfunction

    initial begin
        exp_t e;
        RST_N = 1'b0;
        a_clr = 0; a_valid = 0; a_char = 0; a_iready = 1;
        b_clr = 0; b_valid = 0; b_char = 0; b_iready = 1;
        #12;
        check("rst_valid", a_ovalid, 0);
        check("rst_d", a_d, 0);
        check("rst_digits", a_dig, 0);
        check("rst_err", a_err, 0);
        check("rst_ready", a_ready, 1);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        fork
            forever begin
                @(negedge CLK);
                if (a_ovalid && a_iready) begin
                    if (qa.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_unexpected: got d=%0h digits=%0d err=%0d expected no result", a_d, a_dig, a_err);
                    end else begin
                        e = qa.pop_front();
                        check("a_d", a_d, e.d);
                        check("a_digits", a_dig, e.n);
                        check("a_err", a_err, e.e);
                    end
                end
                if (b_ovalid && b_iready) begin
                    if (qb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected: got d=%0h digits=%0d err=%0d expected no result", b_d, b_dig, b_err);
                    end else begin
                        e = qb.pop_front();
                        check("b_d", b_d, e.d);
                        check("b_digits", b_dig, e.n);
                        check("b_err", b_err, e.e);
                    end
                end
            end
        join_none

        qa.push_back(mk(32'h00001AF3, 4'd4, 2'd0));
        send_str(0, "1aF3");
        check("basic_pre_valid", a_ovalid, 0);
        send(0, 8'h0D);
        check("basic_latency", a_ovalid, 1);

        qa.push_back(mk(32'h0, 4'd0, 2'd1));
        send_str(0, "12G4 ");
        qa.push_back(mk(32'h7, 4'd1, 2'd0));
        send_str(0, "7");
        send(0, 8'h0A);

        qa.push_back(mk(32'hDEADBEEF, 4'd8, 2'd0));
        send_str(0, "DEADBEE");
        check("auto_pre_valid", a_ovalid, 0);
        send(0, "F");
        check("auto_latency", a_ovalid, 1);
        send(0, ",");
        send(0, 8'h0A);

        qa.push_back(mk(32'hA, 4'd1, 2'd0));
        qa.push_back(mk(32'hB, 4'd1, 2'd0));
        send_str(0, "A ");
        a_iready = 1'b0;
        a_char = "B";
        a_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("bp_ready", a_ready, 0);
            check("bp_valid", a_ovalid, 1);
            check("bp_hold_d", a_d, 32'hA);
        end
        @(posedge CLK);
        #1;
        a_iready = 1'b1;
        @(negedge CLK);
        check("bp_release_ready", a_ready, 1);
        @(posedge CLK);
        #1;
        a_valid = 1'b0;
        @(negedge CLK);
        check("bp_consumed", a_ovalid, 0);
        @(posedge CLK);
        #1;
        send(0, " ");

        send_str(0, "12");
        a_clr = 1'b1;
        @(posedge CLK);
        #1;
        a_clr = 1'b0;
        qa.push_back(mk(32'h3, 4'd1, 2'd0));
        send_str(0, "3 ");

        qb.push_back(mk(32'h0, 4'd0, 2'd2));
        send_str(1, "123456789 ");
        qb.push_back(mk(32'h12345678, 4'd8, 2'd0));
        send_str(1, "12345678 ");
        qb.push_back(mk(32'h0, 4'd0, 2'd1));
        send_str(1, "ab ");
        qb.push_back(mk(32'hAB, 4'd2, 2'd0));
        send_str(1, "AB");
        send(1, 8'h0D);

        repeat (3) @(posedge CLK);
        #1;
        send_str(0, "45");
        #1;
        RST_N = 1'b0;
        #1;
        check("arst_valid", a_ovalid, 0);
        check("arst_d", a_d, 0);
        check("arst_digits", a_dig, 0);
        check("arst_err", a_err, 0);
        check("arst_b_d", b_d, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        qa.push_back(mk(32'h5, 4'd1, 2'd0));
        send_str(0, "5 ");

        repeat (5) @(negedge CLK);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
